// File: rtl/word_shift_pkg.sv
// word_shift_pkg: shared helpers for the word_shift_pipe block.
//   tapsel_width(depth) : width of the TapSel index, at least 1 bit.
//   count_width(depth)  : width needed to hold an occupancy of 0..depth.
//   op_e                : per-cycle operation, decoded once at the top level.
package word_shift_pkg;

    function automatic int tapsel_width(input int depth);
        int w;
        w = $clog2(depth);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    typedef enum logic [1:0] {
        OP_HOLD  = 2'd0,
        OP_CLR   = 2'd1,
        OP_SHIFT = 2'd2,
        OP_ROT   = 2'd3
    } op_e;

endpackage

// File: rtl/word_stage.sv
// word_stage: one pipeline stage, a WIDTH-bit data register plus a valid bit.
// Ports:
//   CLK    in   clock, rising edge
//   RST    in   synchronous reset, active-low
//   clr    in   synchronous clear (data and valid to 0)
//   en     in   load d/v_in
//   d      in   WIDTH data to capture
//   v_in   in   valid to capture
//   q      out  registered data
//   v_out  out  registered valid
module word_stage #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    input  logic             v_in,
    output logic [WIDTH-1:0] q,
    output logic             v_out
);

    logic [WIDTH-1:0] data_d, data_q;
    logic             vld_d, vld_q;

    always_comb begin
        data_d = data_q;
        vld_d  = vld_q;
        if (clr) begin
            data_d = '0;
            vld_d  = 1'b0;
        end else if (en) begin
            data_d = d;
            vld_d  = v_in;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            data_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            vld_q  <= vld_d;
        end
    end

    assign q     = data_q;
    assign v_out = vld_q;

endmodule

// File: rtl/word_shift_pipe.sv
// word_shift_pipe: DEPTH-stage, WIDTH-bit shift pipeline with per-stage valid,
// flat tap bus, one selectable tap and occupancy tracking.
// Optional feature: define ROTATE_EN to add the Rot port, which feeds the last
// stage back into stage 0 instead of Din (Count unchanged).
// Ports:
//   CLK    in   clock, rising edge
//   RST    in   synchronous reset, active-low
//   Ce     in   shift enable
//   Clr    in   synchronous flush (overrides Ce and Rot)
//   Din    in   WIDTH data into stage 0
//   Vin    in   valid qualifier for Din
//   TapSel in   stage index driven on Tap/TapV
//   Rot    in   rotate request (ROTATE_EN builds only)
//   Dout   out  last-stage data
//   Vout   out  last-stage valid
//   Taps   out  all stages, stage i at [i*WIDTH +: WIDTH]
//   Tap    out  data of stage TapSel (0 when TapSel >= DEPTH)
//   TapV   out  valid of stage TapSel (0 when TapSel >= DEPTH)
//   Count  out  number of valid stages
//   Full   out  Count == DEPTH
//   Empty  out  Count == 0
//
// op      | meaning
// --------+--------------------------------------------
// OP_HOLD | Ce low: everything holds
// OP_CLR  | flush all stages and Count
// OP_SHIFT| Din/Vin into stage 0, everything moves down
// OP_ROT  | last stage into stage 0, everything moves down
module word_shift_pipe
    import word_shift_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 3
) (
    input  logic                               CLK,
    input  logic                               RST,
    input  logic                               Ce,
    input  logic                               Clr,
    input  logic [WIDTH-1:0]                   Din,
    input  logic                               Vin,
    input  logic [tapsel_width(DEPTH)-1:0]     TapSel,
`ifdef ROTATE_EN
    input  logic                               Rot,
`endif
    output logic [WIDTH-1:0]                   Dout,
    output logic                               Vout,
    output logic [DEPTH*WIDTH-1:0]             Taps,
    output logic [WIDTH-1:0]                   Tap,
    output logic                               TapV,
    output logic [count_width(DEPTH)-1:0]      Count,
    output logic                               Full,
    output logic                               Empty
);

    localparam int TSW = tapsel_width(DEPTH);
    localparam int CW  = count_width(DEPTH);

    logic             rot_req;
    op_e              op;
    logic [WIDTH-1:0] stg_q   [DEPTH];
    logic [WIDTH-1:0] stg_din [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] vld_din;
    logic [CW-1:0]    count_d, count_q;

`ifdef ROTATE_EN
    assign rot_req = Rot;
`else
    assign rot_req = 1'b0;
`endif

    always_comb begin
        op = OP_HOLD;
        if (Clr)
            op = OP_CLR;
        else if (Ce)
            op = rot_req ? OP_ROT : OP_SHIFT;
    end

    // Stage 0 input: rotate feedback or the external word.
    always_comb begin
        stg_din[0] = Din;
        vld_din[0] = Vin;
        if (op == OP_ROT) begin
            stg_din[0] = stg_q[DEPTH-1];
            vld_din[0] = vld_q[DEPTH-1];
        end
        for (int i = 1; i < DEPTH; i++) begin
            stg_din[i] = stg_q[i-1];
            vld_din[i] = vld_q[i-1];
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        word_stage #(.WIDTH(WIDTH)) u_stage (
            .CLK   (CLK),
            .RST   (RST),
            .clr   (op == OP_CLR),
            .en    ((op == OP_SHIFT) || (op == OP_ROT)),
            .d     (stg_din[g]),
            .v_in  (vld_din[g]),
            .q     (stg_q[g]),
            .v_out (vld_q[g])
        );
        assign Taps[g*WIDTH +: WIDTH] = stg_q[g];
    end

    // Rotation conserves valid bits, so only a real shift moves Count.
    always_comb begin
        count_d = count_q;
        case (op)
            OP_CLR:   count_d = '0;
            OP_SHIFT: count_d = count_q + CW'(Vin) - CW'(vld_q[DEPTH-1]);
            default:  count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    always_comb begin
        Tap  = '0;
        TapV = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (TapSel == TSW'(i)) begin
                Tap  = stg_q[i];
                TapV = vld_q[i];
            end
        end
    end

    assign Dout  = stg_q[DEPTH-1];
    assign Vout  = vld_q[DEPTH-1];
    assign Count = count_q;
    assign Full  = (count_q == CW'(DEPTH));
    assign Empty = (count_q == '0);

endmodule

// File: tb/tb_word_shift_pipe.sv
// Directed testbench for word_shift_pipe (WIDTH=4, DEPTH=3).
// Rotate scenarios are compiled in when ROTATE_EN is defined.
module tb_word_shift_pipe;

    logic        CLK = 1'b0;
    logic        RST, Ce, Clr, Vin;
    logic [3:0]  Din;
    logic [1:0]  TapSel;
`ifdef ROTATE_EN
    logic        Rot;
`endif
    logic [3:0]  Dout, Tap;
    logic        Vout, TapV, Full, Empty;
    logic [11:0] Taps;
    logic [1:0]  Count;

    int vectors = 0;
    int miscompares = 0;

    always #5 CLK = ~CLK;

    word_shift_pipe #(.WIDTH(4), .DEPTH(3)) dut (
        .CLK(CLK), .RST(RST), .Ce(Ce), .Clr(Clr), .Din(Din), .Vin(Vin),
        .TapSel(TapSel),
`ifdef ROTATE_EN
        .Rot(Rot),
`endif
        .Dout(Dout), .Vout(Vout), .Taps(Taps), .Tap(Tap), .TapV(TapV),
        .Count(Count), .Full(Full), .Empty(Empty)
    );

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input logic [3:0] d, input logic v);
        Ce = 1'b1; Clr = 1'b0; Din = d; Vin = v;
        step();
        Ce = 1'b0;
    endtask

    task automatic do_reset();
        RST = 1'b0; step(); RST = 1'b1;
    endtask

    task automatic test_reset();
        RST = 1'b0; Ce = 1'b1; Clr = 1'b0; Din = 4'hF; Vin = 1'b1; TapSel = 2'd0;
        step();
        vectors++; if (Taps !== 12'h000) begin miscompares++; $display("FAIL reset_taps got %h want %h", Taps, 12'h000); end
        vectors++; if (Count !== 2'd0) begin miscompares++; $display("FAIL reset_count got %0d want 0", Count); end
        vectors++; if (Empty !== 1'b1 || Full !== 1'b0) begin miscompares++; $display("FAIL reset_flags got E=%b F=%b want E=1 F=0", Empty, Full); end
        vectors++; if (Vout !== 1'b0 || Tap !== 4'h0 || TapV !== 1'b0) begin miscompares++; $display("FAIL reset_outs got Vout=%b Tap=%h TapV=%b want 0 0 0", Vout, Tap, TapV); end
        RST = 1'b1; Ce = 1'b0;
    endtask

    task automatic test_fill();
        push(4'h1, 1'b1);
        vectors++; if (Count !== 2'd1 || Empty !== 1'b0) begin miscompares++; $display("FAIL fill1_count got %0d E=%b want 1 E=0", Count, Empty); end
        push(4'h2, 1'b1);
        push(4'h3, 1'b1);
        vectors++; if (Taps !== 12'h123) begin miscompares++; $display("FAIL fill_taps got %h want %h", Taps, 12'h123); end
        vectors++; if (Dout !== 4'h1 || Vout !== 1'b1) begin miscompares++; $display("FAIL fill_dout got %h/%b want 1/1", Dout, Vout); end
        vectors++; if (Count !== 2'd3 || Full !== 1'b1) begin miscompares++; $display("FAIL fill_count got %0d F=%b want 3 F=1", Count, Full); end
    endtask

    task automatic test_tap_select();
        logic [3:0] exp_tap [4];
        logic       exp_v   [4];
        exp_tap[0] = 4'h3; exp_tap[1] = 4'h2; exp_tap[2] = 4'h1; exp_tap[3] = 4'h0;
        exp_v[0] = 1'b1; exp_v[1] = 1'b1; exp_v[2] = 1'b1; exp_v[3] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            TapSel = 2'(i);
            #1;
            vectors++;
            if (Tap !== exp_tap[i] || TapV !== exp_v[i]) begin
                miscompares++;
                $display("FAIL tapsel%0d got %h/%b want %h/%b", i, Tap, TapV, exp_tap[i], exp_v[i]);
            end
        end
        TapSel = 2'd0;
    endtask

    task automatic test_push_full();
        push(4'h4, 1'b1);
        vectors++; if (Dout !== 4'h2 || Count !== 2'd3 || Taps !== 12'h234) begin miscompares++; $display("FAIL push_full got Dout=%h Count=%0d Taps=%h want 2 3 234", Dout, Count, Taps); end
    endtask

    task automatic test_hold();
        Ce = 1'b0; Clr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            Din = (i % 2 == 0) ? 4'hA : 4'h5; Vin = i[0];
            step();
            vectors++;
            if (Taps !== 12'h234 || Count !== 2'd3 || Dout !== 4'h2 || Full !== 1'b1) begin
                miscompares++;
                $display("FAIL hold%0d got Taps=%h Count=%0d Dout=%h Full=%b want 234 3 2 1", i, Taps, Count, Dout, Full);
            end
        end
    endtask

    task automatic test_bubble();
        logic [1:0] exp_cnt [3];
        logic [3:0] exp_do  [3];
        logic       exp_vo  [3];
        exp_cnt[0] = 2'd2; exp_cnt[1] = 2'd1; exp_cnt[2] = 2'd0;
        exp_do[0]  = 4'h3; exp_do[1]  = 4'h4; exp_do[2]  = 4'h0;
        exp_vo[0]  = 1'b1; exp_vo[1]  = 1'b1; exp_vo[2]  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push(4'h0, 1'b0);
            vectors++;
            if (Count !== exp_cnt[i] || Dout !== exp_do[i] || Vout !== exp_vo[i]) begin
                miscompares++;
                $display("FAIL bubble%0d got Count=%0d Dout=%h Vout=%b want %0d %h %b", i, Count, Dout, Vout, exp_cnt[i], exp_do[i], exp_vo[i]);
            end
        end
        vectors++; if (Empty !== 1'b1) begin miscompares++; $display("FAIL bubble_empty got %b want 1", Empty); end
        push(4'h0, 1'b0);
        vectors++; if (Count !== 2'd0 || Empty !== 1'b1) begin miscompares++; $display("FAIL empty_push got Count=%0d E=%b want 0 1", Count, Empty); end
    endtask

    task automatic test_clr();
        push(4'h5, 1'b1);
        Ce = 1'b1; Clr = 1'b1; Din = 4'hA; Vin = 1'b1;
        step();
        Clr = 1'b0; Ce = 1'b0;
        vectors++; if (Count !== 2'd0 || Taps !== 12'h000 || Empty !== 1'b1) begin miscompares++; $display("FAIL clr_prio got Count=%0d Taps=%h E=%b want 0 000 1", Count, Taps, Empty); end
        push(4'hA, 1'b1);
        vectors++; if (Taps !== 12'h00A || Count !== 2'd1) begin miscompares++; $display("FAIL clr_next got Taps=%h Count=%0d want 00a 1", Taps, Count); end
    endtask

    task automatic test_reset_mid();
        push(4'h6, 1'b1);
        RST = 1'b0; Ce = 1'b1; Din = 4'hE; Vin = 1'b1;
        step();
        RST = 1'b1; Ce = 1'b0;
        vectors++; if (Taps !== 12'h000 || Count !== 2'd0) begin miscompares++; $display("FAIL rst_mid got Taps=%h Count=%0d want 000 0", Taps, Count); end
        push(4'h7, 1'b1);
        vectors++; if (Taps !== 12'h007 || Count !== 2'd1) begin miscompares++; $display("FAIL rst_next got Taps=%h Count=%0d want 007 1", Taps, Count); end
    endtask

    task automatic test_latency();
        do_reset();
        push(4'hC, 1'b1);
        step();
        push(4'h0, 1'b0);
        step(); step();
        vectors++; if (Vout !== 1'b0) begin miscompares++; $display("FAIL lat_early got Vout=%b want 0", Vout); end
        push(4'h0, 1'b0);
        vectors++; if (Dout !== 4'hC || Vout !== 1'b1 || Count !== 2'd1) begin miscompares++; $display("FAIL lat_out got Dout=%h Vout=%b Count=%0d want c 1 1", Dout, Vout, Count); end
    endtask

`ifdef ROTATE_EN
    task automatic test_rotate();
        logic [11:0] exp_taps [3];
        exp_taps[0] = 12'h231; exp_taps[1] = 12'h312; exp_taps[2] = 12'h123;
        do_reset();
        push(4'h1, 1'b1); push(4'h2, 1'b1); push(4'h3, 1'b1);
        for (int i = 0; i < 3; i++) begin
            Ce = 1'b1; Rot = 1'b1; Din = 4'h9; Vin = 1'b1;
            step();
            vectors++;
            if (Taps !== exp_taps[i] || Count !== 2'd3) begin
                miscompares++;
                $display("FAIL rot%0d got Taps=%h Count=%0d want %h 3", i, Taps, Count, exp_taps[i]);
            end
        end
        Ce = 1'b0; Rot = 1'b1;
        step();
        vectors++; if (Taps !== 12'h123) begin miscompares++; $display("FAIL rot_noce got %h want 123", Taps); end
        Ce = 1'b1; Clr = 1'b1; Rot = 1'b1;
        step();
        Ce = 1'b0; Clr = 1'b0; Rot = 1'b0;
        vectors++; if (Taps !== 12'h000 || Count !== 2'd0) begin miscompares++; $display("FAIL rot_clr got Taps=%h Count=%0d want 000 0", Taps, Count); end
    endtask
`endif

    initial begin
        RST = 1'b0; Ce = 1'b0; Clr = 1'b0; Din = '0; Vin = 1'b0; TapSel = '0;
`ifdef ROTATE_EN
        Rot = 1'b0;
`endif
        test_reset();
        test_fill();
        test_tap_select();
        test_push_full();
        test_hold();
        test_bubble();
        test_clr();
        test_reset_mid();
        test_latency();
`ifdef ROTATE_EN
        test_rotate();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
